// File: rtl/sbuf_rd_seq.sv
// rtl/sbuf_rd_seq.sv - systolic buffer read sequencer with skew delay and 2-entry output FIFO
module sbuf_rd_seq #(
    parameter int ADR_W  = 7,
    parameter int DW     = 16,
    parameter int SKEW_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADR_W-1:0]  base_adr_i,
    input  logic [ADR_W:0]    length_i,
    input  logic [SKEW_W-1:0] skew_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADR_W-1:0]  ram_radr_o,
    input  logic [DW-1:0]     ram_rdata_i,
    output logic [DW-1:0]     out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [ADR_W-1:0]    ptr_q, ptr_d;
    logic [ADR_W:0]      rem_q, rem_d;
    logic [SKEW_W-1:0]   cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                inflight_q;

    logic [DW-1:0]       mem_q [2];
    logic                wptr_q;
    logic                rptr_q;
    logic [1:0]          occ_q;

    logic                push;
    logic                pop;
    logic                issue;
    logic [2:0]          load;

    // A read issued last cycle returns its data now and is written into the FIFO.
    assign push = inflight_q;
    assign pop  = (occ_q != 2'd0) && out_ready_i;

    // Words committed after this cycle's pop; a new read is allowed only while
    // that total leaves room for it, which keeps occupancy at or below 2 while
    // still letting a same-cycle pop sustain one word per cycle.
    assign load  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue = (state_q == S_RUN) && (rem_q != '0) && (load < 3'd2);

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign ram_radr_o  = ptr_q;
    assign out_valid_o = (occ_q != 2'd0);
    assign out_data_o  = out_valid_o ? mem_q[rptr_q] : '0;

    // Next-state logic: command capture, skew countdown, read issue and drain completion.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (length_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        ptr_d   = base_adr_i;
                        rem_d   = length_i;
                        cnt_d   = skew_i;
                        state_d = (skew_i != '0) ? S_DELAY : S_RUN;
                    end
                end
            end
            S_DELAY: begin
                cnt_d = cnt_q - SKEW_W'(1);
                if (cnt_q == SKEW_W'(1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (issue) begin
                    ptr_d = ptr_q + ADR_W'(1);
                    rem_d = rem_q - (ADR_W+1)'(1);
                    if (rem_q == (ADR_W+1)'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!inflight_q && (occ_q == 2'd1) && pop) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers; reset abandons any stream without a done pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            inflight_q <= issue;
        end
    end

    // Two-entry output FIFO; push and pop may coincide, reset empties it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            occ_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= ram_rdata_i;
                wptr_q        <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
            end
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_sbuf_rd_seq.sv
// tb/tb_sbuf_rd_seq.sv - self-checking bench for sbuf_rd_seq
module tb_sbuf_rd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  base_adr = '0;
    logic [7:0]  length = '0;
    logic [3:0]  skew_v = '0;
    logic        busy;
    logic        done;
    logic [6:0]  ram_radr;
    logic [15:0] ram_rdata = '0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;

    logic [15:0] ram [128];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Registered-read RAM: address captured on the edge, data visible the next cycle.
    always @(posedge clk) ram_rdata <= ram[ram_radr];

    sbuf_rd_seq #(.ADR_W(7), .DW(16), .SKEW_W(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .base_adr_i  (base_adr),
        .length_i    (length),
        .skew_i      (skew_v),
        .busy_o      (busy),
        .done_o      (done),
        .ram_radr_o  (ram_radr),
        .ram_rdata_i (ram_rdata),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Streams one command and checks it against the expected word list built
    // from the RAM contents; timing is checked only when ready stays high.
    task automatic run_stream(input int base, input int len, input int skw,
                              input bit rnd, input bit poke);
        logic [15:0] exp_q [$];
        int          cyc;
        int          first_v;
        int          done_c;
        int          ntx;
        logic        pv;
        logic        pr;
        logic [15:0] pd;
        for (int i = 0; i < len; i++) exp_q.push_back(ram[(base + i) % 128]);
        start     = 1'b1;
        base_adr  = base[6:0];
        length    = len[7:0];
        skew_v    = skw[3:0];
        out_ready = 1'b1;
        step();
        start    = 1'b0;
        base_adr = 7'($urandom);
        length   = 8'($urandom);
        skew_v   = 4'($urandom);
        cyc = 1; first_v = -1; done_c = -1; ntx = 0; pv = 1'b0; pr = 1'b0; pd = '0;
        while (cyc < 3000) begin
            if (poke && cyc == 6) begin
                start = 1'b1; base_adr = 7'h55; length = 8'd9; skew_v = 4'd2;
            end else begin
                start = 1'b0;
            end
            out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (done) begin
                done_c = cyc;
                break;
            end
            chk("busy_during", busy, 1);
            if (!rnd && cyc >= 1 + skw && cyc < 1 + skw + len)
                chk("radr_seq", ram_radr, (base + cyc - 1 - skw) % 128);
            if (pv && !pr) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, pd);
            end
            if (out_valid) begin
                if (first_v < 0) first_v = cyc;
                if (out_ready) begin
                    if (exp_q.size() == 0) chk("extra_word", 1, 0);
                    else chk("word_data", out_data, exp_q.pop_front());
                    ntx++;
                end
            end else begin
                chk("zero_data", out_data, 0);
            end
            pv = out_valid; pr = out_ready; pd = out_data;
            step();
            cyc++;
        end
        start = 1'b0;
        if (done_c < 0) chk("timeout", 0, 1);
        chk("word_count", ntx, len);
        if (!rnd) begin
            chk("first_valid_cyc", first_v, 3 + skw);
            chk("done_cyc", done_c, 3 + skw + len);
        end
        chk("busy_at_done", busy, 0);
        step();
        chk("done_one_cycle", done, 0);
        chk("idle_valid", out_valid, 0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ram[i] = 16'h1000 + 16'(i);

        rst = 1'b1;
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_radr", ram_radr, 0);
        rst = 1'b0;
        step();

        run_stream(32'h10, 4, 0, 1'b0, 1'b0);
        run_stream(32'h7E, 4, 3, 1'b0, 1'b0);
        run_stream(0, 128, 0, 1'b1, 1'b0);

        start = 1'b1; length = 8'd0; base_adr = 7'h22; skew_v = 4'd5;
        step();
        start = 1'b0;
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        chk("len0_valid", out_valid, 0);
        step();
        chk("len0_done_drop", done, 0);
        chk("len0_busy_after", busy, 0);
        chk("len0_valid_after", out_valid, 0);

        run_stream(32'h40, 12, 1, 1'b0, 1'b1);

        start = 1'b1; base_adr = 7'h30; length = 8'd20; skew_v = 4'd0;
        step();
        start = 1'b0;
        repeat (6) step();
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_data", out_data, 32'(ram[7'h34]));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_data", out_data, 0);
        chk("abort_done", done, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("abort_no_done", done, 0);
            chk("abort_quiet", out_valid, 0);
        end
        run_stream(32'h10, 4, 0, 1'b0, 1'b0);

        for (int i = 0; i < 128; i++) ram[i] = 16'($urandom);
        for (int r = 0; r < 6; r++) begin
            run_stream($urandom_range(0, 127), $urandom_range(1, 40),
                       $urandom_range(0, 15), 1'b1, 1'b0);
        end
        run_stream($urandom_range(0, 127), 128, $urandom_range(0, 15), 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
